// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per frame, LSB first, CYCLE+1 clocks per bit.
// Bytes are taken through a valid/ready handshake while the line is idle.
module uart_tx #(
    parameter int CLK_FRE   = 100,
    parameter int BAND_RATE = 256000,
    parameter int CYCLE     = CLK_FRE * 1000000 / BAND_RATE - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_done,
    output logic       txd
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_BIT0  = 4'd2,
        S_BIT1  = 4'd3,
        S_BIT2  = 4'd4,
        S_BIT3  = 4'd5,
        S_BIT4  = 4'd6,
        S_BIT5  = 4'd7,
        S_BIT6  = 4'd8,
        S_BIT7  = 4'd9,
        S_STOP  = 4'd10
    } state_t;

    localparam logic [15:0] CYC16 = CYCLE[15:0];

    state_t      r_state;
    logic [15:0] r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_ready;
    logic        r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 16'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd     <= 1'b1;
                    r_ready   <= 1'b1;
                    r_bit_cnt <= 16'd0;
                    if (tx_data_valid && r_ready) begin
                        r_shift <= tx_data;
                        r_txd   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START, S_BIT0, S_BIT1, S_BIT2, S_BIT3,
                S_BIT4, S_BIT5, S_BIT6, S_BIT7: begin
                    if (r_bit_cnt == CYC16) begin
                        r_bit_cnt <= 16'd0;
                        r_state   <= state_t'(r_state + 4'd1);
                        // ones shift in from the top, so leaving S_BIT7 drives the stop level
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b1, r_shift[7:1]};
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_bit_cnt == CYC16) begin
                        r_bit_cnt <= 16'd0;
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_done    <= 1'b1;
                        r_txd     <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= 16'd0;
                    r_txd     <= 1'b1;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign txd           = r_txd;
    assign tx_data_ready = r_ready;
    assign tx_done       = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a CYCLE=3 instance for frame detail and a
// default-parameter instance for full-rate bit width and decode.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_ready, tx_done, txd;
    logic [7:0] d2_data = 8'h00;
    logic       d2_valid = 1'b0;
    logic       d2_ready, d2_done, d2_txd;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_done = 0;
    int t_prev = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_FRE(1), .BAND_RATE(250000)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready), .tx_done(tx_done), .txd(txd)
    );

    uart_tx dut2 (
        .clk(clk), .rst(rst), .tx_data(d2_data), .tx_data_valid(d2_valid),
        .tx_data_ready(d2_ready), .tx_done(d2_done), .txd(d2_txd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with ready high; ends at the negedge after the done pulse edge.
    // line[j] is the expected txd level during bit period j (start first).
    task automatic send_frame(input logic [7:0] b, input logic [9:0] line,
                              input logic [7:0] next_b, input bit keep_valid,
                              input bit scramble, input string tag);
        tx_data       = b;
        tx_data_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tx_data       = next_b;
                tx_data_valid = keep_valid;
                chk({tag, " ready_low"}, {31'd0, tx_data_ready}, 32'd0);
            end
            if (i == 20) chk({tag, " ready_mid"}, {31'd0, tx_data_ready}, 32'd0);
            chk($sformatf("%s txd[%0d]", tag, i), {31'd0, txd}, {31'd0, line[i/4]});
            if (i == 39) chk({tag, " no_early_done"}, {31'd0, tx_done}, 32'd0);
            if (scramble) begin
                tx_data       = 8'h5C;
                tx_data_valid = (i < 38) ? ~tx_data_valid : 1'b0;
            end
        end
        @(negedge clk);
        t_done = cyc;
        chk({tag, " done"},  {31'd0, tx_done},       32'd1);
        chk({tag, " ready"}, {31'd0, tx_data_ready}, 32'd1);
        chk({tag, " idle"},  {31'd0, txd},           32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        int         first_rise;

        // reset held for three clocks
        repeat (2) @(negedge clk);
        chk("rst_mid txd",   {31'd0, txd},           32'd1);
        chk("rst_mid ready", {31'd0, tx_data_ready}, 32'd1);
        chk("rst_mid done",  {31'd0, tx_done},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after txd",   {31'd0, txd},           32'd1);
        chk("rst_after ready", {31'd0, tx_data_ready}, 32'd1);
        chk("rst_after done",  {31'd0, tx_done},       32'd0);
        chk("rst_after d2txd", {31'd0, d2_txd},        32'd1);

        // single byte 0x55: line 0,1,0,1,0,1,0,1,0,1
        send_frame(8'h55, 10'h2AA, 8'h00, 1'b0, 1'b0, "b55");
        @(negedge clk);
        chk("b55 done_pulse_once", {31'd0, tx_done}, 32'd0);

        // back-to-back 0x00 then 0xFF with valid held
        send_frame(8'h00, 10'h200, 8'hFF, 1'b1, 1'b0, "b00");
        t_prev = t_done;
        send_frame(8'hFF, 10'h3FE, 8'h00, 1'b0, 1'b0, "bFF");
        chk("b2b done_gap", t_done - t_prev, 32'd41);
        @(negedge clk);

        // 0xA3 with data/valid churn during the frame
        send_frame(8'hA3, 10'h346, 8'h5C, 1'b0, 1'b1, "bA3");
        tx_data_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bA3 no_extra_accept", {30'd0, tx_data_ready, txd}, 32'd3);
        end

        // reset during data bit 3 (bit period 4 covers negedges 16..19)
        tx_data       = 8'hF0;
        tx_data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst bit3", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_frame txd",   {31'd0, txd},           32'd1);
        chk("rst_frame ready", {31'd0, tx_data_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rst_frame done", {31'd0, tx_done}, 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst idle", {29'd0, tx_done, tx_data_ready, txd}, 32'd3);
        end
        send_frame(8'h81, 10'h302, 8'h00, 1'b0, 1'b0, "b81");

        // default parameters: 390 clocks per bit, byte 0x3C
        @(negedge clk);
        d2_data    = 8'h3C;
        d2_valid   = 1'b1;
        bits       = 10'h000;
        first_rise = -1;
        @(posedge clk);
        for (int i = 0; i < 3900; i++) begin
            @(negedge clk);
            if (i == 0) begin
                d2_valid = 1'b0;
                d2_data  = 8'hC3;
            end
            if (i % 390 == 195) bits[i/390] = d2_txd;
            if (d2_txd === 1'b1 && first_rise < 0) first_rise = i;
            if (i == 3899) chk("d2 no_early_done", {31'd0, d2_done}, 32'd0);
        end
        @(negedge clk);
        chk("d2 done",       {31'd0, d2_done},  32'd1);
        chk("d2 ready",      {31'd0, d2_ready}, 32'd1);
        chk("d2 start",      {31'd0, bits[0]},  32'd0);
        chk("d2 byte",       {24'd0, bits[8:1]}, 32'h3C);
        chk("d2 stop",       {31'd0, bits[9]},  32'd1);
        chk("d2 first_rise", first_rise,        32'd1170);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
